// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encodings and bus layouts for the memory-access stage.
package mem_stage_pkg;

   localparam int unsigned EX_TO_MEM_WD = 76;
   localparam int unsigned LOAD_BUS_WD  = 5;
   localparam int unsigned MEM_TO_WB_WD = 70;
   localparam int unsigned MEM_TO_RF_WD = 38;
   localparam int unsigned STALL_BUS_WD = 6;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam int unsigned STALL_MEM = 3;
   localparam int unsigned STALL_WB  = 4;

   // Load-bus bit positions: {lb, lbu, lh, lhu, lw}
   localparam int unsigned LB_IDX  = 4;
   localparam int unsigned LBU_IDX = 3;
   localparam int unsigned LH_IDX  = 2;
   localparam int unsigned LHU_IDX = 1;
   localparam int unsigned LW_IDX  = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_to_mem_t;

endpackage

// File: rtl/mem_load_ext.sv
// Load alignment and sign/zero extension of the data-SRAM read word.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  logic [31:0]            rd,
   input  logic [1:0]             a,
   input  logic [LOAD_BUS_WD-1:0] load_bus,
   output logic [31:0]            data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte/halfword, then extend according to the load type.
   always_comb begin
      byte_s = 8'h00;
      half_s = 16'h0000;
      data   = 32'h0000_0000;
      case (a)
         2'd0:    byte_s = rd[7:0];
         2'd1:    byte_s = rd[15:8];
         2'd2:    byte_s = rd[23:16];
         2'd3:    byte_s = rd[31:24];
         default: byte_s = 8'h00;
      endcase
      if (a[1]) begin
         half_s = rd[31:16];
      end else begin
         half_s = rd[15:0];
      end
      if (load_bus[LB_IDX]) begin
         data = {{24{byte_s[7]}}, byte_s};
      end else if (load_bus[LBU_IDX]) begin
         data = {24'h00_0000, byte_s};
      end else if (load_bus[LH_IDX]) begin
         data = {{16{half_s[15]}}, half_s};
      end else if (load_bus[LHU_IDX]) begin
         data = {16'h0000, half_s};
      end else if (load_bus[LW_IDX]) begin
         data = rd;
      end else begin
         data = rd;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: execute->memory pipeline register, read-word hold buffer,
// load extension and the writeback/forwarding bus outputs.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [STALL_BUS_WD-1:0] stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [LOAD_BUS_WD-1:0]  ex_load_bus,
   input  logic [31:0]             data_sram_rdata,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;
   logic [LOAD_BUS_WD-1:0]  load_bus_r;
   logic [31:0]             rdata_hold_r;
   logic                    hold_vld_r;

   ex_to_mem_t  ex_s;
   logic        bubble_s;
   logic        advance_s;
   logic        reg_load_s;
   logic [31:0] rd_s;
   logic [31:0] load_data_s;
   logic [31:0] rf_wdata_s;
   logic        unused_ok_s;

   assign bubble_s   = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == NO_STOP);
   assign advance_s  = (stall[STALL_MEM] == NO_STOP);
   assign reg_load_s = bubble_s || advance_s;

   // Pipeline register: bubble when only this stage is stopped, else advance or hold.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ex_to_mem_bus_r <= '0;
         load_bus_r      <= '0;
      end else if (bubble_s) begin
         ex_to_mem_bus_r <= '0;
         load_bus_r      <= '0;
      end else if (advance_s) begin
         ex_to_mem_bus_r <= ex_to_mem_bus;
         load_bus_r      <= ex_load_bus;
      end else begin
         ex_to_mem_bus_r <= ex_to_mem_bus_r;
         load_bus_r      <= load_bus_r;
      end
   end

   // Hold buffer: the SRAM word is only valid in the first resident cycle, so keep it across stalls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_hold_r <= 32'h0000_0000;
         hold_vld_r   <= 1'b0;
      end else if (reg_load_s) begin
         rdata_hold_r <= rdata_hold_r;
         hold_vld_r   <= 1'b0;
      end else if (!hold_vld_r && (stall[STALL_WB] == STOP)) begin
         rdata_hold_r <= data_sram_rdata;
         hold_vld_r   <= 1'b1;
      end else begin
         rdata_hold_r <= rdata_hold_r;
         hold_vld_r   <= hold_vld_r;
      end
   end

   assign ex_s        = ex_to_mem_bus_r;
   assign unused_ok_s = ^{ex_s.data_ram_en, ex_s.data_ram_wen, stall[5], stall[2:0]};
   assign rd_s        = hold_vld_r ? rdata_hold_r : data_sram_rdata;

   mem_load_ext u_load_ext (
      .rd       (rd_s),
      .a        (ex_s.ex_result[1:0]),
      .load_bus (load_bus_r),
      .data     (load_data_s)
   );

   assign rf_wdata_s    = ex_s.sel_rf_res ? load_data_s : ex_s.ex_result;
   assign mem_to_wb_bus = {ex_s.pc, ex_s.rf_we, ex_s.rf_waddr, rf_wdata_s};
   assign mem_to_rf_bus = {ex_s.rf_we, ex_s.rf_waddr, rf_wdata_s};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

   logic        clk;
   logic        resetn;
   logic [5:0]  stall;
   logic [75:0] ex_to_mem_bus;
   logic [4:0]  ex_load_bus;
   logic [31:0] data_sram_rdata;
   logic [69:0] mem_to_wb_bus;
   logic [37:0] mem_to_rf_bus;

   int n_checks;
   int n_fail;

   localparam logic [4:0] LD_NONE = 5'b00000;
   localparam logic [4:0] LD_LB   = 5'b10000;
   localparam logic [4:0] LD_LBU  = 5'b01000;
   localparam logic [4:0] LD_LH   = 5'b00100;
   localparam logic [4:0] LD_LHU  = 5'b00010;
   localparam logic [4:0] LD_LW   = 5'b00001;

   mem_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .stall           (stall),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_load_bus     (ex_load_bus),
      .data_sram_rdata (data_sram_rdata),
      .mem_to_wb_bus   (mem_to_wb_bus),
      .mem_to_rf_bus   (mem_to_rf_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [75:0] obs, input logic [75:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [75:0] make_bus(input logic [31:0] pc, input logic sel,
                                            input logic we, input logic [4:0] waddr,
                                            input logic [31:0] res);
      return {pc, sel, 4'h0, sel, we, waddr, res};
   endfunction

   task automatic drive(input logic [31:0] pc, input logic sel, input logic [4:0] waddr,
                        input logic [31:0] res, input logic [4:0] lbus);
      ex_to_mem_bus = make_bus(pc, sel, 1'b1, waddr, res);
      ex_load_bus   = lbus;
   endtask

   // Issue one load, present rdata in its resident cycle and check both buses.
   task automatic run_load(input string tag, input logic [31:0] pc, input logic [4:0] lbus,
                           input logic [1:0] a, input logic [31:0] rdata, input logic [31:0] exp);
      stall = 6'b000000;
      drive(pc, 1'b1, 5'd9, {30'h0400_0000, a}, lbus);
      @(posedge clk);
      #1 data_sram_rdata = rdata;
      #1;
      check_eq({tag, "_rf"}, {38'h0, mem_to_rf_bus}, {38'h0, 1'b1, 5'd9, exp});
      check_eq({tag, "_wb"}, {6'h0, mem_to_wb_bus}, {6'h0, pc, 1'b1, 5'd9, exp});
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      resetn          = 1'b1;
      stall           = 6'b000000;
      ex_to_mem_bus   = 76'h0;
      ex_load_bus     = LD_NONE;
      data_sram_rdata = 32'h0;

      #2 resetn = 1'b0;
      #1;
      check_eq("reset_wb", {6'h0, mem_to_wb_bus}, 76'h0);
      check_eq("reset_rf", {38'h0, mem_to_rf_bus}, 76'h0);
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;

      // Non-load passthrough ignores rdata.
      drive(32'h0040_0010, 1'b0, 5'd5, 32'h0000_ABCD, LD_NONE);
      @(posedge clk);
      #1 data_sram_rdata = 32'hFFFF_0000;
      #1;
      check_eq("addu_rf", {38'h0, mem_to_rf_bus}, {38'h0, 1'b1, 5'd5, 32'h0000_ABCD});
      check_eq("addu_wb", {6'h0, mem_to_wb_bus}, {6'h0, 32'h0040_0010, 1'b1, 5'd5, 32'h0000_ABCD});

      // Mid-cycle reset clears outputs immediately.
      #1 resetn = 1'b0;
      #1;
      check_eq("midrst_wb", {6'h0, mem_to_wb_bus}, 76'h0);
      check_eq("midrst_rf", {38'h0, mem_to_rf_bus}, 76'h0);
      #1 resetn = 1'b1;

      // Bubble: this stage stopped, writeback running.
      drive(32'h0040_0014, 1'b0, 5'd6, 32'h0000_1111, LD_NONE);
      @(posedge clk);
      #2;
      check_eq("pre_bubble_we", {75'h0, mem_to_rf_bus[37]}, 76'h1);
      stall = 6'b001000;
      @(posedge clk);
      #2;
      check_eq("bubble_wb", {6'h0, mem_to_wb_bus}, 76'h0);
      check_eq("bubble_we", {75'h0, mem_to_rf_bus[37]}, 76'h0);

      run_load("lb_a0",  32'h0040_0100, LD_LB,  2'd0, 32'h80FF_7F01, 32'h0000_0001);
      run_load("lb_a1",  32'h0040_0104, LD_LB,  2'd1, 32'h80FF_7F01, 32'h0000_007F);
      run_load("lb_a2",  32'h0040_0108, LD_LB,  2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF);
      run_load("lb_a3",  32'h0040_010C, LD_LB,  2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
      run_load("lbu_a2", 32'h0040_0110, LD_LBU, 2'd2, 32'h80FF_7F01, 32'h0000_00FF);
      run_load("lh_a0",  32'h0040_0114, LD_LH,  2'd0, 32'h8001_FFFE, 32'hFFFF_FFFE);
      run_load("lhu_a2", 32'h0040_0118, LD_LHU, 2'd2, 32'h8001_FFFE, 32'h0000_8001);
      run_load("lh_a3",  32'h0040_011C, LD_LH,  2'd3, 32'h8001_FFFE, 32'hFFFF_8001);
      run_load("lw",     32'h0040_0120, LD_LW,  2'd0, 32'h8001_FFFE, 32'h8001_FFFE);

      // Stall hold: output frozen while rdata changes.
      stall = 6'b000000;
      drive(32'h0040_0200, 1'b1, 5'd7, 32'h0400_0000, LD_LW);
      @(posedge clk);
      #1 data_sram_rdata = 32'h1234_5678;
      stall = 6'b011111;
      #1;
      check_eq("hold_first", {44'h0, mem_to_rf_bus[31:0]}, {44'h0, 32'h1234_5678});
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 data_sram_rdata = 32'hDEAD_BEEF;
         #1;
         check_eq("hold_stalled", {44'h0, mem_to_rf_bus[31:0]}, {44'h0, 32'h1234_5678});
      end
      run_load("after_release", 32'h0040_0204, LD_LW, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D);

      // Reset mid-stall discards the resident load and hold buffer.
      stall = 6'b000000;
      drive(32'h0040_0300, 1'b1, 5'd8, 32'h0400_0000, LD_LW);
      @(posedge clk);
      #1 data_sram_rdata = 32'h55AA_55AA;
      stall = 6'b011111;
      @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      check_eq("stallrst_wb", {6'h0, mem_to_wb_bus}, 76'h0);
      #1 resetn = 1'b1;
      @(posedge clk);
      #2;
      check_eq("stallrst_held_wb", {6'h0, mem_to_wb_bus}, 76'h0);
      check_eq("stallrst_held_rf", {38'h0, mem_to_rf_bus}, 76'h0);
      run_load("post_stallrst", 32'h0040_0304, LD_LHU, 2'd0, 32'h0000_8001, 32'h0000_8001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage. It registers the execute→memory bus and the load-type bus and takes the data-SRAM read word for the load issued one cycle earlier. It aligns and extends that word per load type, selects between load data and the ALU result, and drives the memory→writeback bus and the forwarding bus back to decode. A hold buffer keeps the read word stable while the stage is stalled.

## Interface

Parameters (macros in `lib/defines.vh`):
- `EX_TO_MEM_WD`: 76. Layout is {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- `LoadBus`: 5. Layout is {inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw}, one-hot or all zero.
- `MEM_TO_WB_WD`: 70. Layout is {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- `MEM_TO_RF_WD`: 38. Layout is {rf_we, rf_waddr, rf_wdata}.
- `StallBus`: 6. `Stop` = 1, `NoStop` = 0.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: reset. One clock; reset is asynchronous and active-low.
- `stall` in `StallBus`: pipeline stall vector. Bit 3 is this stage's input, bit 4 is writeback.
- `ex_to_mem_bus` in `EX_TO_MEM_WD`: instruction leaving execute.
- `ex_load_bus` in `LoadBus`: load type leaving execute.
- `data_sram_rdata` in 32: read word. It is valid in the first cycle an instruction occupies this stage.
- `mem_to_wb_bus` out `MEM_TO_WB_WD`: to writeback.
- `mem_to_rf_bus` out `MEM_TO_RF_WD`: forwarding to decode.

## Operation

- Input register (`ex_to_mem_bus_r`, `load_bus_r`) updates on the rising edge of `clk`:
  - `resetn` = 0: clear asynchronously to 0.
  - `stall[3]`=Stop and `stall[4]`=NoStop: load 0 (a bubble).
  - `stall[3]`=NoStop: load the inputs.
  - Otherwise: hold.
- Hold buffer: `rdata_hold` is 32 bits and `hold_vld` is 1 bit, both reset to 0.
  - Any cycle in which the input register loads (new instruction or bubble): `hold_vld` is 0 at the next edge.
  - First resident cycle with `hold_vld`=0 and `stall[4]`=Stop: capture `rdata_hold` <= `data_sram_rdata` and set `hold_vld`=1.
- Effective read word: `rd` = `hold_vld` ? `rdata_hold` : `data_sram_rdata`.
- Alignment uses `a` = ex_result[1:0], little-endian:
  - lb/lbu: byte `rd[8a+7:8a]`. lb sign-extends, lbu zero-extends.
  - lh/lhu: halfword `rd[16a[1]+15:16a[1]]`. lh sign-extends, lhu zero-extends. `a[0]` is ignored; there is no alignment exception.
  - lw, or load bus all zero: `rd` unchanged.
- `rf_wdata` = `sel_rf_res` ? aligned load data : `ex_result`.
- `mem_to_wb_bus` = {pc, rf_we, rf_waddr, rf_wdata}.
- `mem_to_rf_bus` = {rf_we, rf_waddr, rf_wdata}. Both buses are combinational from the register, the hold buffer and `rd`.
- A bubble has rf_we=0, so it never writes or forwards.

## Timing

- Latency from execute to this stage is one edge. The output is combinational within the resident cycle.
- `data_sram_rdata` is only trusted in the first resident cycle. In later stalled cycles the output must be identical to the first cycle, even if `data_sram_rdata` changes.
- Reset: every output is 0 from reset assertion until the first non-stalled load after release. Reset mid-stall discards the resident instruction and the hold buffer.
- Simultaneous load-register-load and capture: the load has priority, so `hold_vld` is 0 at the next edge.
- Non-load instructions (`sel_rf_res`=0) ignore `rd` entirely. The hold buffer may capture, but it has no effect on the outputs.

## Structure

- Bus widths, `Stop`/`NoStop` and the load-bus bit order live in `lib/defines.vh`. Do not hard-code field offsets outside the unpacking assign.
- One sub-module, `mem_load_ext`: combinational, with inputs `rd`, `a` and the load bus, and 32-bit extended data as output.
- The top level holds the pipeline register, the hold buffer and the output muxing.

## Test plan

- Reset and bubble:
  - Assert `resetn`=0 mid-cycle → both output buses are 0 immediately.
  - Apply `stall`=6'b001000 → the resident register becomes 0 and rf_we=0.
- Byte loads: rdata=0x80FF7F01.
  - lb with a=0..3 → rf_wdata 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - lbu with a=2 → 0x000000FF.
- Halfword and word loads: rdata=0x8001FFFE.
  - lh with a=0 → 0xFFFFFFFE.
  - lhu with a=2 → 0x00008001.
  - lh with a=3 → 0xFFFF8001.
  - lw → 0x8001FFFE.
- Stall hold:
  - lw is resident with rdata=0x12345678, then `stall`=6'b011111 for 3 cycles while rdata changes to 0xDEADBEEF → output stays 0x12345678 throughout.
  - After release, the next instruction sees live rdata.
- Non-load passthrough: addu result 0x0000ABCD with rf_waddr=5 and rf_we=1 → mem_to_rf_bus = {1, 5, 0x0000ABCD} and mem_to_wb_bus carries the same pc.
